// File: rtl/microsequencer_if.sv
// Sequencer handshake bundle: control-word fields and status in,
// next/current microstate and sticky error flags out.
interface microsequencer_if #(
  parameter int STATE_W = 10
);
  logic [2:0]         ns_sel;
  logic [2:0]         cond_sel;
  logic               cond_inv;
  logic [STATE_W-1:0] cr_addr;
  logic [STATE_W-1:0] enc_addr;
  logic               moc;
  logic [3:0]         flags;
  logic               cond_true;
  logic               irq;
  logic [STATE_W-1:0] next_state;
  logic [STATE_W-1:0] current_state;
  logic               stall;
  logic               stack_err;
  logic               timeout;

  modport master (
    output ns_sel, cond_sel, cond_inv, cr_addr, enc_addr,
    output moc, flags, cond_true, irq,
    input  next_state, current_state, stall, stack_err, timeout
  );

  modport slave (
    input  ns_sel, cond_sel, cond_inv, cr_addr, enc_addr,
    input  moc, flags, cond_true, irq,
    output next_state, current_state, stall, stack_err, timeout
  );
endinterface

// File: rtl/microsequencer.sv
// Microprogram next-address sequencer with return stack
// and bounded WAIT timeout trap.
module microsequencer #(
  parameter int               STATE_W     = 10,
  parameter int               STACK_DEPTH = 4,
  parameter int               WAIT_LIMIT  = 255,
  parameter logic [STATE_W-1:0] FETCH_STATE = 10'd1,
  parameter logic [STATE_W-1:0] TRAP_STATE  = 10'd240
) (
  input logic            clk,
  input logic            reset,
  microsequencer_if.slave bus
);
  localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int CW = $clog2(WAIT_LIMIT + 1);

  logic [STATE_W-1:0] cur;
  logic [STATE_W-1:0] nxt;
  logic [STATE_W-1:0] inc;
  logic [STATE_W-1:0] stack [STACK_DEPTH];
  logic [DW-1:0]      depth;
  logic [CW-1:0]      wait_cnt;
  logic               err_q;
  logic               to_q;

  logic          c_raw;
  logic          c;
  logic          full;
  logic          empty;
  logic [PW-1:0] top_idx;
  logic [PW-1:0] push_idx;
  logic          push;
  logic          pop;
  logic          hold;
  logic          trap;
  logic          ovf;
  logic          unf;
  logic          stall_c;

  assign inc      = cur + STATE_W'(1);
  assign full     = (depth == DW'(STACK_DEPTH));
  assign empty    = (depth == '0);
  assign top_idx  = PW'(depth - DW'(1));
  assign push_idx = full ? PW'(STACK_DEPTH - 1) : PW'(depth);

  // condition select, mode decode and next-address selection
  always_comb begin
    c_raw   = 1'b0;
    nxt     = inc;
    push    = 1'b0;
    pop     = 1'b0;
    hold    = 1'b0;
    trap    = 1'b0;
    ovf     = 1'b0;
    unf     = 1'b0;
    unique case (bus.cond_sel)
      3'd0: c_raw = bus.moc;
      3'd1: c_raw = bus.flags[3];
      3'd2: c_raw = bus.flags[2];
      3'd3: c_raw = bus.flags[1];
      3'd4: c_raw = bus.flags[0];
      3'd5: c_raw = bus.cond_true;
      3'd6: c_raw = 1'b1;
      3'd7: c_raw = bus.irq;
    endcase
    c = c_raw ^ bus.cond_inv;
    unique case (bus.ns_sel)
      3'd0: nxt = bus.enc_addr;
      3'd1: nxt = inc;
      3'd2: nxt = bus.cr_addr;
      3'd3: nxt = c ? bus.cr_addr : inc;
      3'd4: nxt = c ? bus.cr_addr : bus.enc_addr;
      3'd5: begin
        push = 1'b1;
        ovf  = full;
        nxt  = bus.cr_addr;
      end
      3'd6: begin
        if (empty) begin
          unf = 1'b1;
          nxt = FETCH_STATE;
        end else begin
          pop = 1'b1;
          nxt = stack[top_idx];
        end
      end
      3'd7: begin
        if (c) begin
          nxt = inc;
        end else if (wait_cnt == CW'(WAIT_LIMIT)) begin
          trap = 1'b1;
          nxt  = TRAP_STATE;
        end else begin
          hold = 1'b1;
          nxt  = cur;
        end
      end
    endcase
    stall_c = (bus.ns_sel == 3'd7) & ~c;
    if (reset) begin
      nxt     = '0;
      stall_c = 1'b0;
    end
  end

  // state, depth, wait count and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= '0;
      depth    <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      cur      <= nxt;
      wait_cnt <= hold ? wait_cnt + CW'(1) : '0;
      if (push && !full) depth <= depth + DW'(1);
      if (pop) depth <= depth - DW'(1);
      if (ovf || unf) err_q <= 1'b1;
      if (trap) to_q <= 1'b1;
    end
  end

  // return-address storage; overflow overwrites the top entry
  always_ff @(posedge clk) begin
    if (!reset && push) stack[push_idx] <= inc;
  end

  assign bus.next_state    = nxt;
  assign bus.current_state = cur;
  assign bus.stall         = stall_c;
  assign bus.stack_err     = err_q;
  assign bus.timeout       = to_q;
endmodule

// File: tb/tb_microsequencer.sv
// Directed vector bench for microsequencer: table of
// single-step modes plus stack, wait and reset sequences.
module tb_microsequencer;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  microsequencer_if #(.STATE_W(10)) bus ();

  microsequencer #(
    .STATE_W(10),
    .STACK_DEPTH(4),
    .WAIT_LIMIT(8),
    .FETCH_STATE(10'd1),
    .TRAP_STATE(10'd240)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ns;
    logic [2:0] cs;
    logic       inv;
    logic [9:0] cr;
    logic [9:0] enc;
    logic       moc;
    logic [3:0] flags;
    logic       ct;
    logic       irq;
    logic [9:0] exp_next;
    logic       exp_stall;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] ns, input logic [9:0] cr,
                    input logic [2:0] cs, input logic inv,
                    input logic moc);
    bus.ns_sel    = ns;
    bus.cr_addr   = cr;
    bus.cond_sel  = cs;
    bus.cond_inv  = inv;
    bus.moc       = moc;
    bus.enc_addr  = '0;
    bus.flags     = '0;
    bus.cond_true = 1'b0;
    bus.irq       = 1'b0;
    #1;
  endtask

  task automatic step(input string name, input int exp);
    chk({name, "_next"}, int'(bus.next_state), exp);
    tick();
    chk({name, "_cur"}, int'(bus.current_state), exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //           ns cs inv cr    enc  moc flags   ct irq exp  stl
    vecs[0]  = '{1, 0, 0, 0,    0,   0, 4'b0000, 0, 0, 1,    0};
    vecs[1]  = '{0, 0, 0, 0,    20,  0, 4'b0000, 0, 0, 20,   0};
    vecs[2]  = '{2, 0, 0, 50,   0,   0, 4'b0000, 0, 0, 50,   0};
    vecs[3]  = '{3, 2, 0, 100,  0,   0, 4'b0100, 0, 0, 100,  0};
    vecs[4]  = '{2, 0, 0, 50,   0,   0, 4'b0000, 0, 0, 50,   0};
    vecs[5]  = '{3, 2, 1, 100,  0,   0, 4'b0100, 0, 0, 51,   0};
    vecs[6]  = '{4, 2, 1, 100,  77,  0, 4'b0100, 0, 0, 77,   0};
    vecs[7]  = '{4, 3, 0, 300,  5,   0, 4'b0010, 0, 0, 300,  0};
    vecs[8]  = '{3, 6, 0, 600,  0,   0, 4'b0000, 0, 0, 600,  0};
    vecs[9]  = '{3, 7, 0, 10,   0,   0, 4'b0000, 0, 0, 601,  0};
    vecs[10] = '{3, 5, 0, 900,  0,   0, 4'b0000, 1, 0, 900,  0};
    vecs[11] = '{3, 4, 0, 10,   0,   0, 4'b0001, 0, 0, 10,   0};
    vecs[12] = '{3, 1, 0, 500,  0,   0, 4'b0111, 0, 0, 11,   0};
    vecs[13] = '{2, 0, 0, 1023, 0,   0, 4'b0000, 0, 0, 1023, 0};
    vecs[14] = '{1, 0, 0, 0,    0,   0, 4'b0000, 0, 0, 0,    0};
    vecs[15] = '{7, 0, 0, 0,    0,   1, 4'b0000, 0, 0, 1,    0};
    vecs[16] = '{7, 7, 1, 0,    0,   0, 4'b0000, 0, 1, 1,    1};

    reset = 1'b1;
    op(3'd1, 10'd0, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_cur", int'(bus.current_state), 0);
    chk("rst_next", int'(bus.next_state), 0);
    chk("rst_stall", int'(bus.stall), 0);
    chk("rst_err", int'(bus.stack_err), 0);
    chk("rst_to", int'(bus.timeout), 0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      bus.ns_sel    = vecs[i].ns;
      bus.cond_sel  = vecs[i].cs;
      bus.cond_inv  = vecs[i].inv;
      bus.cr_addr   = vecs[i].cr;
      bus.enc_addr  = vecs[i].enc;
      bus.moc       = vecs[i].moc;
      bus.flags     = vecs[i].flags;
      bus.cond_true = vecs[i].ct;
      bus.irq       = vecs[i].irq;
      #1;
      chk($sformatf("vec%0d_stall", i), int'(bus.stall),
          int'(vecs[i].exp_stall));
      step($sformatf("vec%0d", i), int'(vecs[i].exp_next));
    end

    op(3'd2, 10'd100, 3'd0, 1'b0, 1'b0);
    step("nest_jmp", 100);
    op(3'd5, 10'd200, 3'd0, 1'b0, 1'b0);
    step("call1", 200);
    op(3'd5, 10'd300, 3'd0, 1'b0, 1'b0);
    step("call2", 300);
    op(3'd5, 10'd400, 3'd0, 1'b0, 1'b0);
    step("call3", 400);
    op(3'd5, 10'd500, 3'd0, 1'b0, 1'b0);
    step("call4", 500);
    chk("call4_err", int'(bus.stack_err), 0);
    op(3'd5, 10'd600, 3'd0, 1'b0, 1'b0);
    step("call5", 600);
    chk("call5_err", int'(bus.stack_err), 1);
    op(3'd6, 10'd0, 3'd0, 1'b0, 1'b0);
    step("ret1", 501);
    step("ret2", 301);
    step("ret3", 201);
    step("ret4", 101);
    step("ret5_uflow", 1);

    op(3'd2, 10'd3, 3'd0, 1'b0, 1'b0);
    step("moc_jmp", 3);
    op(3'd7, 10'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("moc_stall%0d", i), int'(bus.stall), 1);
      step($sformatf("moc_hold%0d", i), 3);
    end
    bus.moc = 1'b1;
    #1;
    chk("moc_go_stall", int'(bus.stall), 0);
    step("moc_go", 4);
    chk("moc_to", int'(bus.timeout), 0);

    op(3'd2, 10'd3, 3'd0, 1'b0, 1'b0);
    step("lim_jmp", 3);
    op(3'd7, 10'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step($sformatf("lim_hold%0d", i), 3);
    bus.moc = 1'b1;
    #1;
    step("lim_cwins", 4);
    chk("lim_to", int'(bus.timeout), 0);

    op(3'd2, 10'd3, 3'd0, 1'b0, 1'b0);
    step("to_jmp", 3);
    op(3'd7, 10'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step($sformatf("to_hold%0d", i), 3);
    chk("to_trap_stall", int'(bus.stall), 1);
    step("to_trap", 240);
    chk("to_flag", int'(bus.timeout), 1);
    op(3'd1, 10'd0, 3'd0, 1'b0, 1'b0);
    step("to_inc", 241);
    chk("to_sticky", int'(bus.timeout), 1);

    op(3'd2, 10'd100, 3'd0, 1'b0, 1'b0);
    step("mid_jmp", 100);
    op(3'd5, 10'd200, 3'd0, 1'b0, 1'b0);
    step("mid_call1", 200);
    op(3'd5, 10'd300, 3'd0, 1'b0, 1'b0);
    step("mid_call2", 300);
    op(3'd7, 10'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step($sformatf("mid_hold%0d", i), 300);
    reset = 1'b1;
    #1;
    chk("mid_rst_next", int'(bus.next_state), 0);
    chk("mid_rst_stall", int'(bus.stall), 0);
    tick();
    chk("mid_rst_cur", int'(bus.current_state), 0);
    chk("mid_rst_err", int'(bus.stack_err), 0);
    chk("mid_rst_to", int'(bus.timeout), 0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) step($sformatf("post_hold%0d", i), 0);
    op(3'd6, 10'd0, 3'd0, 1'b0, 1'b0);
    step("post_ret", 1);
    chk("post_ret_err", int'(bus.stack_err), 1);
    chk("post_to", int'(bus.timeout), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/microsequencer.md
# microsequencer

Next-address sequencer for the microprogrammed control unit. It registers the current microstate and computes the 10-bit next-state address that drives the control microstore. It uses the sequencing fields of the current control word, the instruction encoder address, status flags and the memory-operation-complete (MOC) handshake. It also provides a small return stack for microsubroutines and a bounded-wait timeout that traps hung memory cycles.

## Interface
- STATE_W, 10, microstate address width
- STACK_DEPTH, 4, return-stack entries (power of 2)
- WAIT_LIMIT, 255, max cycles a WAIT state may hold before trapping
- FETCH_STATE, 10'd1, target of RETURN on stack underflow
- TRAP_STATE, 10'd240, target on wait timeout
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- ns_sel  in  3  next-state mode from current control word
- cond_sel  in  3  condition source select
- cond_inv  in  1  invert selected condition
- cr_addr  in  STATE_W  branch/call target from control word
- enc_addr  in  STATE_W  decoded-instruction entry state from encoder
- moc  in  1  memory operation complete
- flags  in  4  {N,Z,C,V} from status register
- cond_true  in  1  condition-tester result
- irq  in  1  pending interrupt request
- next_state  out  STATE_W  combinational next address to microstore
- current_state  out  STATE_W  registered present state
- stall  out  1  high while a WAIT is not yet satisfied
- stack_err  out  1  sticky overflow/underflow flag
- timeout  out  1  sticky wait-timeout flag

## Operation
- Selected condition c = mux(cond_sel): 0 moc, 1 N, 2 Z, 3 C, 4 V, 5 cond_true, 6 constant 1, 7 irq; then c ^= cond_inv.
- inc = current_state + 1, truncated to STATE_W (wraps at 1023 -> 0).
- ns_sel modes:
  - 0 DECODE: next = enc_addr.
  - 1 INC: next = inc.
  - 2 JUMP: next = cr_addr.
  - 3 BRANCH: next = c ? cr_addr : inc.
  - 4 BRDEC: next = c ? cr_addr : enc_addr.
  - 5 CALL: push inc; next = cr_addr.
  - 6 RETURN: pop; next = popped value.
  - 7 WAIT: next = c ? inc : current_state.
- Return stack: LIFO with a depth counter 0..STACK_DEPTH.
  - CALL when full: top entry is overwritten, depth unchanged, stack_err set.
  - RETURN when empty: next = FETCH_STATE, depth stays 0, stack_err set.
- Wait counter: increments each cycle WAIT holds (c=0) and clears whenever the state advances.
  - When the counter reaches WAIT_LIMIT with c still 0, next = TRAP_STATE, timeout is set and the counter clears.
  - If c=1 on the limit cycle, c wins: next = inc and no timeout.
- stall = (ns_sel==7) & ~c, combinational.
- stack_err and timeout stay set until reset.

## Timing
- current_state <= next_state at every rising clk; there is no enable.
- next_state is combinational from the current inputs. Microstore output is valid the same cycle.
- Reset has priority over all modes. On the reset edge:
  - current_state = 0
  - depth = 0
  - wait counter = 0
  - stack_err = 0
  - timeout = 0
- While reset is high, next_state is forced to 0 and stall is forced to 0.
- Reset mid-WAIT or mid-subroutine discards all stack contents and the wait count.
- CALL push and RETURN pop take effect on the same edge that loads current_state.
- Latency:
  - mode decision to state change: 1 cycle.
  - WAIT with moc already high: 1 cycle, no stall.
  - WAIT with moc arriving after k cycles: state advances on edge k+1.
- Only one stack operation is possible per cycle; there is no simultaneous push/pop case.

## Test plan
- Reset release, then fetch path: reset 2 cycles -> current_state=0, next_state=0. Then ns_sel=1 from state 0 -> 1; ns_sel=0 with enc_addr=20 from state 1 -> 20.
- BRANCH with inversion: state 50, ns_sel=3, cond_sel=2, flags Z=1, cr_addr=100. With cond_inv=0 -> 100; with cond_inv=1 -> 51. Mode 4 with c=0 -> enc_addr.
- Microsubroutine nesting: 5 nested CALLs with STACK_DEPTH=4 -> the 5th call sets stack_err=1. Four RETURNs unwind correctly, with the deepest return value replaced by the 5th push. The 5th RETURN -> FETCH_STATE (1).
- MOC handshake: state 3, ns_sel=7, cond_sel=0, moc low 4 cycles then high. Required: stall=1 for 4 cycles, current_state=3 throughout, then 4 on the next edge; timeout stays 0.
- Timeout: WAIT_LIMIT=8, moc never asserted -> after 8 held cycles next_state=240 and timeout=1. Timeout remains 1 through later states until reset.
- Reset mid-operation plus wrap: depth=2 and wait count=5, assert reset -> all state cleared and the next RETURN underflows. Separately, INC from state 1023 -> 0.
